iir_filter_mc: RTL
==================

# iir_filter_mc

Time-multiplexed, multi-channel, direct-form-I IIR filter with runtime-loadable coefficients. It is the parametrised successor to the fixed single-channel bandpass stage and sits between the sample front-end and the downstream detection logic. Each input sample carries a channel tag, and the block keeps independent x/y history per channel. All channels share one double-buffered coefficient set, and the block accepts signed input samples.

## Interface
- SIG_WIDTH, 8, input sample width; two's complement signed
- COEF_WIDTH, 32, coefficient and y-history width; fixed point Q(COEF_WIDTH-FRAC_WIDTH).FRAC_WIDTH
- FRAC_WIDTH, 16, fractional bits of coefficients and y-history
- ORDER, 6, filter order, 1..15
- CHANNELS, 4, number of independent channels, 1..16
- CH_W = max(1, $clog2(CHANNELS)) and IDX_W = $clog2(ORDER+1) are derived localparams
- clk_in  in  1  system clock; all logic is on its rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- x_in  in  SIG_WIDTH  signed input sample
- x_ch_in  in  CH_W  channel tag of x_in
- x_valid_in  in  1  sample valid
- x_ready_out  out  1  block can accept a sample; reset 1
- coef_we_in  in  1  write one shadow coefficient
- coef_sel_in  in  1  0 = a-bank, 1 = b-bank
- coef_idx_in  in  IDX_W  coefficient index, 0..ORDER
- coef_data_in  in  COEF_WIDTH  coefficient value
- coef_commit_in  in  1  one-cycle pulse: copy shadow to active bank
- clear_in  in  1  one-cycle pulse: zero all channel histories
- y_out  out  SIG_WIDTH+1  signed filtered sample; reset 0
- y_ch_out  out  CH_W  channel tag of y_out; reset 0
- y_valid_out  out  1  one-cycle output strobe; reset 0

## Operation
- The state machine has three states: IDLE, CALC and UPDATE. Reset sends it to IDLE. x_ready_out = (state == IDLE) && !commit_pending.
- IDLE: if x_valid_in && x_ready_out, the block latches x_in and x_ch_in, clears acc and k, and moves to CALC.
- CALC: the block performs one MAC per cycle for k = 0..ORDER.
  - k = 0: acc = b[0]·x << FRAC_WIDTH.
  - k ≥ 1: acc += (b[k]·xh[ch][k-1] << FRAC_WIDTH) − a[k]·yh[ch][k-1].
  - a[0] is stored but never used; it is implicitly 1.0.
- Accumulator: signed, width 2·COEF_WIDTH + IDX_W + 1, with 2·FRAC_WIDTH fractional bits. All products are sign-extended. The x-history is signed.
- UPDATE:
  - y_new = acc >>> FRAC_WIDTH, reduced to COEF_WIDTH bits.
  - The block shifts xh[ch] and yh[ch] by one and writes x and y_new at index 0.
  - y_out = acc >>> 2·FRAC_WIDTH, reduced to SIG_WIDTH+1 bits. y_ch_out = ch. y_valid_out pulses.
  - The state returns to IDLE.
- Bit reduction wraps by default; see Configuration. Right shifts are arithmetic and truncate toward −∞.
- Only the addressed channel's history changes. All other channels are untouched.
- Tag out of range (x_ch_in ≥ CHANNELS): the sample is accepted, then the block returns to IDLE with no CALC and no output.
- Coefficient writes go to the shadow bank in any state. A write to index > ORDER is ignored.
- coef_commit_in sets commit_pending. The copy happens on the first cycle the block is in IDLE with commit_pending set, and no sample is accepted that cycle. An in-flight sample always uses the old bank.
- If coef_we_in and the commit copy fall on the same cycle, the write lands in the shadow only and is not committed.
- Reset values: the shadow and active banks become pass-through (b[0] = 1 << FRAC_WIDTH, all other coefficients 0). All histories become 0.
- clear_in in IDLE: all histories are zeroed on the next edge.
- clear_in while busy: the request is latched. The in-flight sample still emits its y_out, but in UPDATE the histories are zeroed instead of shifted.
- Asynchronous reset mid-CALC aborts the sample. No y_valid_out is produced.

## Timing
- A sample accepted at edge T produces y_valid_out high during the cycle after edge T+ORDER+2.
- Latency is ORDER+3 cycles from accept to the output strobe.
- x_ready_out is low from T+1 and returns high in the cycle after UPDATE.
- Maximum throughput is one sample per ORDER+3 cycles. A commit costs one extra cycle.
- y_out and y_ch_out hold their value until the next UPDATE.
- y_valid_out is never high for two consecutive cycles.

## Configuration
- IIR_SATURATE_EN defined: both reductions (y_new and y_out) clamp to the most positive or most negative value of the target width.
- IIR_SATURATE_EN undefined: both reductions drop the upper bits (two's-complement wrap). Logic area is smaller.

## Structure
- Package iir_pkg holds:
  - the state enum (IDLE, CALC, UPDATE);
  - the bank-select constants COEF_A = 0 and COEF_B = 1;
  - a function computing the pass-through reset value of a coefficient;
  - a saturate/wrap function that is conditional on IIR_SATURATE_EN.
- Sub-module iir_mac is the signed multiply-accumulate datapath. Its inputs are coefficient, operand, a shift flag, a subtract flag, clear and enable. Its output is acc.
- The histories are register arrays [CHANNELS][ORDER].

## Test plan
- Reset defaults, ORDER=6, CHANNELS=4: send x = 5, −3, 127, −128 on ch 2 → y_out = 5, −3, 127, −128 on ch 2, each y_valid_out exactly 9 cycles after accept.
- Commit a[1] = 0xFFFF8000 (−0.5), b[0] = 1.0, then an impulse x = 64 followed by zeros on ch 0 → y = 64, 32, 16, 8, 4, 2, 1, 0. Ch 1 fed zeros in between → y = 0 always.
- Commit a[1] = −1.0 (0xFFFF0000), b[0] = 1.0, step x = 127 on ch 0 → y_out grows until it overflows SIG_WIDTH+1 bits. With IIR_SATURATE_EN it holds 255 (0xFF in 9 bits); without it, it wraps to negative.
- Commit pulsed mid-CALC → the in-flight sample uses the old coefficients, x_ready_out stays low one extra cycle, and the next sample uses the new ones.
- Pulse clear_in during CALC of ch 3 (b[0]=1, a[1]=−0.5) → the in-flight sample outputs normally. The next sample x = 10 outputs 10, not 10 + history.
- With CHANNELS=3, x_ch_in = 3 → no y_valid_out, x_ready_out is back high 2 cycles later, and the histories are unchanged.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and helpers for the multi-channel IIR filter.
// IIR_SATURATE_EN selects clamping instead of wrapping in reduce().
package iir_pkg;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;

  localparam logic COEF_A = 1'b0;
  localparam logic COEF_B = 1'b1;

  // Pass-through filter: b[0] = 1.0, everything else 0.
  function automatic logic [63:0] coef_reset(input logic sel, input int idx, input int frac);
    return (sel == COEF_B && idx == 0) ? (64'd1 << frac) : 64'd0;
  endfunction

  // Narrow a signed value to w bits; caller truncates the result to w.
  function automatic logic [63:0] reduce(input logic signed [127:0] v, input int w);
`ifdef IIR_SATURATE_EN
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) return hi[63:0];
    if (v < lo) return lo[63:0];
    return v[63:0];
`else
    return 64'(v & ((128'd1 << w) - 128'd1));
`endif
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Signed multiply-accumulate slice: acc +/- (coef * operand) [<< FRAC_WIDTH].
module iir_mac #(
  parameter int COEF_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int ACC_W      = 68
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [COEF_WIDTH-1:0] coef,
  input  logic signed [COEF_WIDTH-1:0] operand,
  input  logic                         shift,
  input  logic                         sub,
  input  logic                         clr,
  input  logic                         en,
  output logic signed [ACC_W-1:0]      acc
);

  logic signed [2*COEF_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        term;

  assign prod = (2*COEF_WIDTH)'(coef) * (2*COEF_WIDTH)'(operand);
  assign term = shift ? (ACC_W'(prod) <<< FRAC_WIDTH) : ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sub ? acc - term : acc + term;
  end

endmodule

// File: rtl/iir_filter_mc.sv
// Time-multiplexed multi-channel direct-form-I IIR with double-buffered coefficients.
// Define IIR_SATURATE_EN to clamp y history and y_out instead of wrapping.
module iir_filter_mc
  import iir_pkg::*;
#(
  parameter int SIG_WIDTH  = 8,
  parameter int COEF_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int ORDER      = 6,
  parameter int CHANNELS   = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W     = $clog2(ORDER + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [SIG_WIDTH-1:0]  x_in,
  input  logic [CH_W-1:0]       x_ch_in,
  input  logic                  x_valid_in,
  output logic                  x_ready_out,
  input  logic                  coef_we_in,
  input  logic                  coef_sel_in,
  input  logic [IDX_W-1:0]      coef_idx_in,
  input  logic [COEF_WIDTH-1:0] coef_data_in,
  input  logic                  coef_commit_in,
  input  logic                  clear_in,
  output logic [SIG_WIDTH:0]    y_out,
  output logic [CH_W-1:0]       y_ch_out,
  output logic                  y_valid_out
);

  localparam int ACC_W = 2*COEF_WIDTH + IDX_W + 1;

  state_t state, state_nx;
  logic [IDX_W-1:0]             k, hidx;
  logic signed [SIG_WIDTH-1:0]  x_lat;
  logic [CH_W-1:0]              ch;
  logic                         bad_ch, clear_pending, commit_pending;
  logic                         accept, copy, clr_now, in_calc;

  logic [COEF_WIDTH-1:0] sh_a  [ORDER+1];
  logic [COEF_WIDTH-1:0] sh_b  [ORDER+1];
  logic [COEF_WIDTH-1:0] act_a [ORDER+1];
  logic [COEF_WIDTH-1:0] act_b [ORDER+1];

  logic signed [SIG_WIDTH-1:0]  xh [CHANNELS][ORDER];
  logic signed [COEF_WIDTH-1:0] yh [CHANNELS][ORDER];

  logic signed [COEF_WIDTH-1:0] op_b;
  logic signed [ACC_W-1:0]      acc_b, acc_a, acc;
  logic signed [127:0]          acc_ext;
  logic signed [COEF_WIDTH-1:0] y_new;
  logic signed [SIG_WIDTH:0]    y_red;

  assign x_ready_out = (state == IDLE) && !commit_pending;
  assign accept      = x_valid_in && x_ready_out;
  assign copy        = (state == IDLE) && commit_pending;
  assign in_calc     = (state == CALC);
  assign clr_now     = clear_in || clear_pending;
  assign hidx        = (k == '0) ? '0 : k - IDX_W'(1);
  assign op_b        = COEF_WIDTH'((k == '0) ? x_lat : xh[ch][hidx]);

  // b-terms carry the extra FRAC_WIDTH shift; a-terms subtract y history.
  iir_mac #(.COEF_WIDTH(COEF_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .ACC_W(ACC_W)) u_mac_b (
    .clk(clk_in), .rst_n(rst_n_in), .coef(act_b[k]), .operand(op_b),
    .shift(1'b1), .sub(1'b0), .clr(accept), .en(in_calc), .acc(acc_b));

  iir_mac #(.COEF_WIDTH(COEF_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .ACC_W(ACC_W)) u_mac_a (
    .clk(clk_in), .rst_n(rst_n_in), .coef(act_a[k]), .operand(yh[ch][hidx]),
    .shift(1'b0), .sub(1'b1), .clr(accept), .en(in_calc && (k != '0)), .acc(acc_a));

  assign acc     = acc_b + acc_a;
  assign acc_ext = {{(128-ACC_W){acc[ACC_W-1]}}, acc};
  assign y_new   = COEF_WIDTH'(reduce(acc_ext >>> FRAC_WIDTH, COEF_WIDTH));
  assign y_red   = (SIG_WIDTH+1)'(reduce(acc_ext >>> (2*FRAC_WIDTH), SIG_WIDTH + 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (int'(x_ch_in) < CHANNELS) ? CALC : UPDATE;
      CALC:    if (int'(k) == ORDER) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      k              <= '0;
      x_lat          <= '0;
      ch             <= '0;
      bad_ch         <= 1'b0;
      clear_pending  <= 1'b0;
      commit_pending <= 1'b0;
      y_out          <= '0;
      y_ch_out       <= '0;
      y_valid_out    <= 1'b0;
    end else begin
      if (accept) begin
        k      <= '0;
        x_lat  <= $signed(x_in);
        ch     <= x_ch_in;
        bad_ch <= (int'(x_ch_in) >= CHANNELS);
      end else if (in_calc) begin
        k <= k + IDX_W'(1);
      end
      commit_pending <= coef_commit_in || (commit_pending && !copy);
      clear_pending  <= in_calc && clr_now;
      y_valid_out    <= (state == UPDATE) && !bad_ch;
      if (state == UPDATE && !bad_ch) begin
        y_out    <= y_red;
        y_ch_out <= ch;
      end
    end
  end

  // Shadow writes land even on the copy cycle; the copy takes the old shadow.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i <= ORDER; i++) begin
        sh_a[i]  <= COEF_WIDTH'(coef_reset(COEF_A, i, FRAC_WIDTH));
        sh_b[i]  <= COEF_WIDTH'(coef_reset(COEF_B, i, FRAC_WIDTH));
        act_a[i] <= COEF_WIDTH'(coef_reset(COEF_A, i, FRAC_WIDTH));
        act_b[i] <= COEF_WIDTH'(coef_reset(COEF_B, i, FRAC_WIDTH));
      end
    end else begin
      if (copy) begin
        for (int i = 0; i <= ORDER; i++) begin
          act_a[i] <= sh_a[i];
          act_b[i] <= sh_b[i];
        end
      end
      if (coef_we_in && int'(coef_idx_in) <= ORDER) begin
        if (coef_sel_in == COEF_B) sh_b[coef_idx_in] <= coef_data_in;
        else                       sh_a[coef_idx_in] <= coef_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < ORDER; i++) begin
          xh[c][i] <= '0;
          yh[c][i] <= '0;
        end
    end else if (state != CALC && clr_now) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < ORDER; i++) begin
          xh[c][i] <= '0;
          yh[c][i] <= '0;
        end
    end else if (state == UPDATE && !bad_ch) begin
      for (int i = ORDER - 1; i > 0; i--) begin
        xh[ch][i] <= xh[ch][i-1];
        yh[ch][i] <= yh[ch][i-1];
      end
      xh[ch][0] <= x_lat;
      yh[ch][0] <= y_new;
    end
  end

endmodule
